// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply/divide sequencer.
//
// Computes MUL (low word), MULHU (high word), DIVU (quotient) and REMU
// (remainder) in 32 iterations. Each iteration uses the shared 32-bit ALU
// for the add or subtract. The block itself only shifts and muxes.
// The ALU lines are owned while busy. In IDLE they rest at ADD/0/0.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_op            00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   req_a, req_b      multiplicand/dividend, multiplier/divisor
//   flush             synchronous abort, priority over req_valid
//   resp_valid/data   one-cycle result pulse, registered data
//   busy              high in RUN and DONE
//   alu_a/b/control   shared ALU drive
//   alu_dout/cout     shared ALU result and carry (SUB: cout=1 iff A<B)

package muldiv_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_SUB = 4'd1,
    ALU_OP_AND = 4'd2,
    ALU_OP_OR  = 4'd3,
    ALU_OP_XOR = 4'd4,
    ALU_OP_SLL = 4'd5,
    ALU_OP_SRL = 4'd6,
    ALU_OP_SRA = 4'd7
  } alu_control_t;
endpackage

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,  // only 32 matches the shared ALU
  parameter int CNT_W = 6    // 2**CNT_W must exceed XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic             flush,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_data,
  output logic             busy,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output alu_control_t     alu_control,
  input  logic [XLEN-1:0]  alu_dout,
  input  logic             alu_cout
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // hi: product high word / remainder R; lo: multiplier+product low / quotient Q
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  // m: multiplicand M / divisor D
  logic [XLEN-1:0]   m_q, m_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;

  logic              accept;
  logic              last_iter;
  logic [XLEN:0]     div_s;   // shifted remainder {R, Q[msb]}
  logic              q_bit;

  assign accept    = (state_q == S_IDLE) && req_valid && !flush;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
  assign div_s     = {hi_q, lo_q[XLEN-1]};
  // Subtract succeeds when S overflowed 32 bits or S[31:0] >= D (no borrow)
  assign q_bit     = div_s[XLEN] | ~alu_cout;

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 2'b00;
      cnt_q        <= {CNT_W{1'b0}};
      hi_q         <= {XLEN{1'b0}};
      lo_q         <= {XLEN{1'b0}};
      m_q          <= {XLEN{1'b0}};
      resp_valid_q <= 1'b0;
      resp_data_q  <= {XLEN{1'b0}};
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      m_q          <= m_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
        else        state_d = S_IDLE;
      end
      S_RUN: begin
        if (flush)          state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
        else                state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: ALU drive and the response pulse request
  always_comb begin
    alu_control  = ALU_OP_ADD;
    alu_a        = {XLEN{1'b0}};
    alu_b        = {XLEN{1'b0}};
    resp_valid_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (op_q[1]) begin
          alu_control = ALU_OP_SUB;
          alu_a       = div_s[XLEN-1:0];
          alu_b       = m_q;
        end else begin
          alu_control = ALU_OP_ADD;
          alu_a       = hi_q;
          alu_b       = lo_q[0] ? m_q : {XLEN{1'b0}};
        end
      end
      S_DONE:  resp_valid_d = ~flush;
      S_IDLE:  resp_valid_d = 1'b0;
      default: resp_valid_d = 1'b0;
    endcase
  end

  // Datapath: operand latch, one shift-add / restoring-divide step, result select
  always_comb begin
    op_d        = op_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    m_d         = m_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          cnt_d = {CNT_W{1'b0}};
          hi_d  = {XLEN{1'b0}};
          if (req_op[1]) begin
            lo_d = req_a;
            m_d  = req_b;
          end else begin
            lo_d = req_b;
            m_d  = req_a;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (op_q[1]) begin
          hi_d = q_bit ? alu_dout : div_s[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], q_bit};
        end else begin
          // {HI,LO} = {cout, sum, LO} >> 1
          hi_d = {alu_cout, alu_dout[XLEN-1:1]};
          lo_d = {alu_dout[0], lo_q[XLEN-1:1]};
        end
      end
      S_DONE: begin
        if (!flush) begin
          case (op_q)
            OP_MUL:   resp_data_d = lo_q;
            OP_MULHU: resp_data_d = hi_q;
            OP_DIVU:  resp_data_d = lo_q;
            OP_REMU:  resp_data_d = hi_q;
            default:  resp_data_d = lo_q;
          endcase
        end else begin
          resp_data_d = resp_data_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [31:0]  req_a;
  logic [31:0]  req_b;
  logic         flush;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         busy;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  alu_control_t alu_control;
  logic [31:0]  alu_dout;
  logic         alu_cout;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_dout(alu_dout), .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model
  logic [32:0] alu_full;
  always_comb begin
    alu_full = 33'd0;
    case (alu_control)
      ALU_OP_ADD: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_OP_SUB: alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      default:    alu_full = 33'd0;
    endcase
    alu_dout = alu_full[31:0];
    alu_cout = alu_full[32];
  end

  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic accept_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name, input bit chk_lat);
    int lat;
    bit seen;
    lat = 0; seen = 1'b0;
    accept_req(op, a, b);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; lat = i; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid within 40 cycles", name);
    end else begin
      checks++;
      if (resp_data !== exp) begin
        errors++;
        $display("FAIL %s data: got %h expected %h", name, resp_data, exp);
      end
      if (chk_lat) begin
        checks++;
        if (lat !== 34) begin
          errors++;
          $display("FAIL %s latency: got %0d expected 34", name, lat);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'd0 ||
        alu_control !== ALU_OP_ADD || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++;
      $display("FAIL %s: got rdy=%b busy=%b rv=%b rd=%h ctl=%0d a=%h b=%h expected 1 0 0 0 0 0 0",
               name, req_ready, busy, resp_valid, resp_data, alu_control, alu_a, alu_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_mul();
    int bad;
    bad = 0;
    accept_req(2'b00, 32'h0001_0003, 32'h0002_0005);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy: got busy=%b ready=%b expected 1 0", busy, req_ready);
    end
    repeat (40) @(negedge clk);
    run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "mul_small", 1'b1);
    // Result must hold after the pulse
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h000B_000F) begin
      errors++;
      $display("FAIL mul_hold: got rv=%b rd=%h expected 0 000b000f", resp_valid, resp_data);
    end
    run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, "mulhu_small", 1'b1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", 1'b1);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_max", 1'b1);
    if (bad != 0) errors++;
  endtask

  task automatic test_div();
    run_op(2'b10, 32'd100, 32'd7, 32'd14, "divu_100_7", 1'b1);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, "remu_100_7", 1'b1);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1", 1'b1);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, "remu_max_1", 1'b1);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "remu_big_divisor", 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "divu_big_divisor", 1'b1);
  endtask

  task automatic test_div_zero();
    run_op(2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu_by_zero", 1'b1);
    run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, "remu_by_zero", 1'b1);
  endtask

  task automatic test_flush();
    bit seen;
    // Flush during RUN at iteration 10
    accept_req(2'b00, 32'd9, 32'd9);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_run_idle: got busy=%b ready=%b expected 0 1", busy, req_ready);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_run_suppress: got resp_valid=1 expected 0");
    end
    run_op(2'b10, 32'd1000, 32'd3, 32'd333, "after_flush", 1'b1);

    // Flush in the DONE cycle suppresses the pulse
    accept_req(2'b11, 32'd50, 32'd7);
    repeat (33) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_busy: got busy=%b expected 1", busy);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_done_suppress: got resp_valid=1 expected 0");
    end

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; flush = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    accept_req(2'b10, 32'hFFFF_FFFF, 32'd3);
    repeat (5) @(negedge clk);
    checks++;
    if (alu_control !== ALU_OP_SUB) begin
      errors++;
      $display("FAIL rst_mid_pre: got ctl=%0d expected SUB", alu_control);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exps[4];
    int acc[4];
    int idx, rcnt;
    bit viol, take;
    ops[0] = 2'b00; as[0] = 32'h1234_5678; bs[0] = 32'h10;        exps[0] = 32'h2345_6780;
    ops[1] = 2'b10; as[1] = 32'd1000;      bs[1] = 32'd10;        exps[1] = 32'd100;
    ops[2] = 2'b01; as[2] = 32'h8000_0000; bs[2] = 32'd4;         exps[2] = 32'd2;
    ops[3] = 2'b11; as[3] = 32'd1000;      bs[3] = 32'd7;         exps[3] = 32'd6;
    idx = 0; rcnt = 0; viol = 1'b0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = ops[0]; req_a = as[0]; req_b = bs[0];
    for (int cyc = 0; cyc < 200 && rcnt < 4; cyc++) begin
      if (resp_valid) begin
        checks++;
        if (resp_data !== exps[rcnt]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h expected %h", rcnt, resp_data, exps[rcnt]);
        end
        rcnt++;
      end
      if (req_ready === busy) viol = 1'b1;
      take = req_ready && (idx < 4);
      if (take) acc[idx] = cyc;
      @(posedge clk);
      #1;
      if (take) begin
        idx++;
        if (idx < 4) begin
          req_op = ops[idx]; req_a = as[idx]; req_b = bs[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (rcnt !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses expected 4", rcnt);
    end
    checks++;
    if (viol) begin
      errors++;
      $display("FAIL b2b_ready_busy: got req_ready equal to busy expected complementary");
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc[i+1] - acc[i] !== 34) begin
        errors++;
        $display("FAIL b2b_interval%0d: got %0d expected 34", i, acc[i+1] - acc[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 600; k++) begin
      op = 2'(k % 4);
      a  = $urandom;
      b  = ((k % 8) < 4) ? $urandom : 32'($urandom_range(0, 255));
      run_op(op, a, b, golden(op, a, b), "random", 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
